lifo_stack_ext: RTL and testbench

Parametrised LIFO stack with count reporting, programmable almost-full/almost-empty thresholds, a simultaneous push+pop swap mode, a read-valid strobe, a combinational top-of-stack peek and sticky overflow/underflow error flags. It is the general-purpose operand/return stack for datapath and control blocks. It replaces the fixed-function stack in new designs. All state is synchronous to a single clock.

---
 rtl/lifo_stack_ext.sv | 153 +++++++++++++++
 tb/tb_lifo_stack_ext.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack_ext.sv
// lifo_stack_ext: parametrised LIFO stack with occupancy count, threshold flags,
// push+pop swap/bypass, registered pop data with a valid strobe, a
// combinational top-of-stack peek and sticky overflow/underflow flags.
module lifo_stack_ext #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             data_out,
  output logic                         dout_valid,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  // Storage is never reset: entries above the stack pointer are dead, and the
  // peek output is masked to zero while the stack is empty.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] data_out_reg, data_out_next;
  logic             dout_valid_reg, dout_valid_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic             full_int;
  logic             empty_int;
  logic [CW-1:0]    top_idx_full;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_word;

  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [DEPTH-1:0] we_vec;

  // Status decode from the registered count only, never from the live requests.
  always_comb begin
    full_int     = (count_reg == DEPTH_C);
    empty_int    = (count_reg == '0);
    top_idx_full = count_reg - ONE_C;
    top_idx      = top_idx_full[AW-1:0];
    top_word     = mem[top_idx];
  end

  assign full         = full_int;
  assign empty        = empty_int;
  assign almost_full  = (count_reg >= AFULL_C);
  assign almost_empty = (count_reg <= AEMPTY_C);
  assign top          = empty_int ? '0 : top_word;
  assign count        = count_reg;
  assign data_out     = data_out_reg;
  assign dout_valid   = dout_valid_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Next-state decode: clr wins, then single push, single pop, then swap/bypass.
  always_comb begin
    count_next      = count_reg;
    data_out_next   = data_out_reg;
    dout_valid_next = 1'b0;
    overflow_next   = overflow_reg;
    underflow_next  = underflow_reg;
    wr_en           = 1'b0;
    wr_idx          = top_idx;

    if (clr) begin
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else if (push && !pop) begin
      if (!full_int) begin
        wr_en      = 1'b1;
        wr_idx     = count_reg[AW-1:0];
        count_next = count_reg + ONE_C;
      end else begin
        overflow_next = 1'b1;
      end
    end else if (pop && !push) begin
      if (!empty_int) begin
        data_out_next   = top_word;
        dout_valid_next = 1'b1;
        count_next      = count_reg - ONE_C;
      end else begin
        underflow_next = 1'b1;
      end
    end else if (push && pop) begin
      // Swap replaces the top entry in place; on an empty stack the word
      // simply passes straight through to data_out.
      dout_valid_next = 1'b1;
      if (!empty_int) begin
        data_out_next = top_word;
        wr_en         = 1'b1;
        wr_idx        = top_idx;
      end else begin
        data_out_next = data_in;
      end
    end
  end

  // One-hot per-entry write enables.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we_vec[gi] = wr_en && (wr_idx == AW'(gi));
    end
  endgenerate

  // Storage write port; no reset so it maps onto plain distributed storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we_vec[i]) begin
        mem[i] <= data_in;
      end
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg      <= '0;
      data_out_reg   <= '0;
      dout_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      count_reg      <= count_next;
      data_out_reg   <= data_out_next;
      dout_valid_reg <= dout_valid_next;
      overflow_reg   <= overflow_next;
      underflow_reg  <= underflow_next;
    end
  end

endmodule

// File: tb/tb_lifo_stack_ext.sv
// Directed self-checking bench for lifo_stack_ext (DEPTH=8, WIDTH=8).
module tb_lifo_stack_ext;

  logic       clk;
  logic       rstn;
  logic       clr;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       dout_valid;
  logic [7:0] top;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  lifo_stack_ext #(.DEPTH(8), .WIDTH(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .clr         (clr),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .data_out    (data_out),
    .dout_valid  (dout_valid),
    .top         (top),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one request for one rising edge, then return 1ns after that edge.
  task automatic step(input logic p, input logic po, input logic c, input logic [7:0] d);
    push    = p;
    pop     = po;
    clr     = c;
    data_in = d;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    data_in = 8'h00;
    $display("step push=%0d pop=%0d clr=%0d din=%02h -> count=%0d top=%02h dout=%02h dv=%0d ovf=%0d unf=%0d",
             p, po, c, d, count, top, data_out, dout_valid, overflow, underflow);
  endtask

  initial begin
    logic [7:0] w;
    rstn = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    #12;
    check("rst_count", count, 0);
    check("rst_dout", data_out, 0);
    check("rst_dv", dout_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_top", top, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      w = 8'(i * 17);
      step(1'b1, 1'b0, 1'b0, w);
      check("fill_count", count, i);
      check("fill_top", top, w);
      check("fill_afull", almost_full, (i >= 7) ? 1 : 0);
      check("fill_aempty", almost_empty, (i <= 1) ? 1 : 0);
      check("fill_full", full, (i == 8) ? 1 : 0);
      check("fill_dv", dout_valid, 0);
    end

    // Swap at full
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    check("swap_dout", data_out, 8'h88);
    check("swap_dv", dout_valid, 1);
    check("swap_count", count, 8);
    check("swap_top", top, 8'hAA);
    check("swap_ovf", overflow, 0);

    // Overflow when full
    step(1'b1, 1'b0, 1'b0, 8'h99);
    check("ovf_count", count, 8);
    check("ovf_top", top, 8'hAA);
    check("ovf_flag", overflow, 1);
    check("ovf_dv", dout_valid, 0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("ovf_sticky", overflow, 1);
    check("idle_dout_hold", data_out, 8'h88);

    // Drain: AA, 77, 66, ..., 11
    for (int i = 8; i >= 1; i--) begin
      w = (i == 8) ? 8'hAA : 8'(i * 17);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("drain_dout", data_out, w);
      check("drain_dv", dout_valid, 1);
      check("drain_count", count, i - 1);
    end
    check("drain_empty", empty, 1);
    check("drain_top", top, 0);
    check("drain_ovf_sticky", overflow, 1);

    // Underflow
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("unf_flag", underflow, 1);
    check("unf_dv", dout_valid, 0);
    check("unf_dout", data_out, 8'h11);
    check("unf_count", count, 0);

    // Clear beats a simultaneous push
    step(1'b1, 1'b0, 1'b1, 8'h33);
    check("clr_count", count, 0);
    check("clr_ovf", overflow, 0);
    check("clr_unf", underflow, 0);
    check("clr_dout_hold", data_out, 8'h11);
    check("clr_empty", empty, 1);
    check("clr_full", full, 0);

    // Bypass on empty
    step(1'b1, 1'b1, 1'b0, 8'h5C);
    check("byp_dout", data_out, 8'h5C);
    check("byp_dv", dout_valid, 1);
    check("byp_count", count, 0);
    check("byp_ovf", overflow, 0);
    check("byp_unf", underflow, 0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("byp_dv_pulse", dout_valid, 0);

    // Six pushes then a pop leaves count=5 with dout_valid high
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("pre_rst_count", count, 5);
    check("pre_rst_dout", data_out, 8'hC6);
    check("pre_rst_dv", dout_valid, 1);

    // Asynchronous reset between edges
    #3;
    rstn = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_dout", data_out, 0);
    check("arst_dv", dout_valid, 0);
    check("arst_top", top, 0);
    check("arst_full", full, 0);
    check("arst_afull", almost_full, 0);
    check("arst_empty", empty, 1);
    #1;
    rstn = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h01);
    check("post_rst_count", count, 1);
    check("post_rst_top", top, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
